// File: rtl/pipe_stage_latch.sv
// Inter-stage pipeline latch: valid/ready handshake, 2-entry skid buffer, flush and NOP bubbles.
// Optional stall counter enabled by defining PIPE_LATCH_PERF_EN.
module pipe_stage_latch #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int CTRL_W = 14,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_PC_next,
  input  logic [DATA_W-1:0] in_ALU_result,
  input  logic [DATA_W-1:0] in_data_reg,
  input  logic [CTRL_W-1:0] in_ctrl_signals,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_PC_next,
  output logic [DATA_W-1:0] out_ALU_result,
  output logic [DATA_W-1:0] out_data_reg,
  output logic [CTRL_W-1:0] out_ctrl_signals,
  output logic [RD_W-1:0]   out_rd,
  output logic [1:0]        state_dbg
`ifdef PIPE_LATCH_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_count
`endif
);

  // Handshake: a transfer happens on a side exactly when its valid and ready are both high
  // at a rising clock edge; ready never depends combinationally on the opposite side.

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc_next;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] data_reg;
    logic [CTRL_W-1:0] ctrl;
    logic [RD_W-1:0]   rd;
  } entry_t;

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  state_t state, state_n;
  entry_t main_q, skid_q, in_entry;
  logic   accept, deliver;
  logic   load_main_in, load_main_skid, load_skid;

  assign in_entry = '{pc_next: in_PC_next, alu_result: in_ALU_result,
                      data_reg: in_data_reg, ctrl: in_ctrl_signals, rd: in_rd};

  assign in_ready  = (state != FULL) & ~reset;
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;
  assign state_dbg = state;

  always_comb begin
    state_n        = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_n      = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && !deliver) begin
          state_n   = FULL;
          load_skid = 1'b1;
        end else if (deliver && !accept) begin
          state_n = EMPTY;
        end else if (accept && deliver) begin
          load_main_in = 1'b1;
        end
      end
      FULL: begin
        if (deliver) begin
          state_n        = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  // Flush squashes occupancy only; payload registers keep their last contents.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      state <= state_n;
      if (load_main_in) begin
        main_q <= in_entry;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_entry;
      end
    end
  end

  // Empty stage presents a NOP: control and rd are zeroed, data fields are left as-is.
  assign out_PC_next      = main_q.pc_next;
  assign out_ALU_result   = main_q.alu_result;
  assign out_data_reg     = main_q.data_reg;
  assign out_ctrl_signals = out_valid ? main_q.ctrl : '0;
  assign out_rd           = out_valid ? main_q.rd : '0;

`ifdef PIPE_LATCH_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count <= '0;
    end else if (out_valid && !out_ready && (stall_count != '1)) begin
      stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Bench for pipe_stage_latch: directed vector table, FIFO scoreboard sequence,
// and stall-counter checks when PIPE_LATCH_PERF_EN is defined.
module tb_pipe_stage_latch;

`ifdef PIPE_LATCH_PERF_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_PC_next, in_ALU_result, in_data_reg;
  logic [13:0] in_ctrl_signals;
  logic [4:0]  in_rd;
  logic [31:0] out_PC_next, out_ALU_result, out_data_reg;
  logic [13:0] out_ctrl_signals;
  logic [4:0]  out_rd;
  logic [1:0]  state_dbg;
`ifdef PIPE_LATCH_PERF_EN
  logic [CNT_W-1:0] stall_count;
`endif

  pipe_stage_latch #(.PC_W(32), .DATA_W(32), .CTRL_W(14), .RD_W(5), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_PC_next(in_PC_next), .in_ALU_result(in_ALU_result), .in_data_reg(in_data_reg),
    .in_ctrl_signals(in_ctrl_signals), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_PC_next(out_PC_next), .out_ALU_result(out_ALU_result), .out_data_reg(out_data_reg),
    .out_ctrl_signals(out_ctrl_signals), .out_rd(out_rd),
    .state_dbg(state_dbg)
`ifdef PIPE_LATCH_PERF_EN
    , .stall_count(stall_count)
`endif
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        rst, fl, iv, ordy;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        e_ov, e_ir;
    logic [4:0]  e_rd;
    logic [31:0] e_pc;
  } vec_t;
  vec_t vecs[$];

  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [13:0] ctrl_of(input logic [4:0] rd);
    return {4'hA, 5'b0, rd};
  endfunction

  // driver tasks
  task automatic drive(input logic rst, input logic fl, input logic iv,
                       input logic [4:0] rd, input logic [31:0] pc, input logic ordy);
    reset           = rst;
    flush           = fl;
    in_valid        = iv;
    in_rd           = rd;
    in_PC_next      = pc;
    in_ALU_result   = pc << 4;
    in_data_reg     = {pc[15:0], pc[15:0]};
    in_ctrl_signals = ctrl_of(rd);
    out_ready       = ordy;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic rst, input logic fl, input logic iv, input logic [4:0] rd,
                     input logic [31:0] pc, input logic ordy, input logic e_ov,
                     input logic e_ir, input logic [4:0] e_rd, input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.rd = rd; v.pc = pc; v.ordy = ordy;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_rd = e_rd; v.e_pc = e_pc;
    vecs.push_back(v);
  endtask

  task automatic check_sb(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_q.size() != 2));
    if (exp_q.size() != 0) begin
      check({tag, ".out_pc"}, out_PC_next, exp_q[0]);
      check({tag, ".out_rd"}, 32'(out_rd), 32'(5'((exp_q[0] - 32'h1000) >> 2)));
    end
  endtask

  initial begin
    logic [39:0] iv_pat, or_pat;
    int          seq;
    logic        acc, del;
    logic [31:0] pc;

    // reset held 3 cycles, then release
    add(1,0,0, 0, 32'h0,  0, 0,0, 0, 32'h0);
    add(1,0,0, 0, 32'h0,  0, 0,0, 0, 32'h0);
    add(1,0,0, 0, 32'h0,  0, 0,0, 0, 32'h0);
    add(0,0,0, 0, 32'h0,  1, 0,1, 0, 32'h0);
    // back-to-back stream with out_ready=1
    add(0,0,1, 4, 32'h4,  1, 1,1, 4, 32'h4);
    add(0,0,1, 8, 32'h8,  1, 1,1, 8, 32'h8);
    add(0,0,1,12, 32'hC,  1, 1,1,12, 32'hC);
    add(0,0,0, 0, 32'h0,  1, 0,1, 0, 32'hC);
    // backpressure: A, B fill the latch, C waits upstream
    add(0,0,1, 1, 32'h10, 0, 1,1, 1, 32'h10);
    add(0,0,1, 2, 32'h14, 0, 1,0, 1, 32'h10);
    add(0,0,1, 3, 32'h18, 0, 1,0, 1, 32'h10);
    add(0,0,1, 3, 32'h18, 1, 1,1, 2, 32'h14);
    add(0,0,1, 3, 32'h18, 1, 1,1, 3, 32'h18);
    add(0,0,0, 0, 32'h0,  1, 0,1, 0, 32'h18);
    // ONE with simultaneous accept and deliver
    add(0,0,1, 5, 32'h20, 0, 1,1, 5, 32'h20);
    add(0,0,1, 6, 32'h24, 1, 1,1, 6, 32'h24);
    // fill to FULL, then flush with in_valid high
    add(0,0,1, 7, 32'h28, 0, 1,0, 6, 32'h24);
    add(0,1,1, 8, 32'h2C, 0, 0,1, 0, 32'h24);
    add(0,0,0, 0, 32'h0,  1, 0,1, 0, 32'h24);
    add(0,0,1, 9, 32'h30, 1, 1,1, 9, 32'h30);
    add(0,0,0, 0, 32'h0,  1, 0,1, 0, 32'h30);
    // reset outranks flush and accept, clears payload
    add(1,1,1,10, 32'h34, 1, 0,0, 0, 32'h0);
    add(0,0,0, 0, 32'h0,  1, 0,1, 0, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].rd, vecs[i].pc, vecs[i].ordy);
      tick();
      check($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      check($sformatf("v%0d.out_rd", i), 32'(out_rd), 32'(vecs[i].e_rd));
      check($sformatf("v%0d.out_ctrl", i), 32'(out_ctrl_signals),
            vecs[i].e_ov ? 32'(ctrl_of(vecs[i].e_rd)) : 32'h0);
      check($sformatf("v%0d.out_pc", i), out_PC_next, vecs[i].e_pc);
      check($sformatf("v%0d.out_alu", i), out_ALU_result, vecs[i].e_pc << 4);
    end

    // scoreboard sequence: irregular valid/ready patterns, strict FIFO order expected
    iv_pat = 40'hFB7DE6F5BD;
    or_pat = 40'h3C96A5C3F0;
    seq    = 0;
    for (int c = 0; c < 40; c++) begin
      pc = 32'h1000 + 32'(4 * seq);
      drive(0, 0, iv_pat[c], 5'(seq), pc, or_pat[c]);
      #1;
      check_sb($sformatf("sb%0d", c));
      acc = iv_pat[c] && (exp_q.size() != 2);
      del = or_pat[c] && (exp_q.size() != 0);
      tick();
      if (del) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(pc);
        seq++;
      end
    end
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0, 0, 32'h0, 1);
      #1;
      check_sb($sformatf("drain%0d", c));
      del = exp_q.size() != 0;
      tick();
      if (del) void'(exp_q.pop_front());
    end
    check("drain.empty", 32'(out_valid), 32'h0);

`ifdef PIPE_LATCH_PERF_EN
    drive(1, 0, 0, 0, 32'h0, 0);
    tick();
    check("perf.reset", 32'(stall_count), 32'h0);
    drive(0, 0, 1, 5'd11, 32'h40, 0);
    tick();
    drive(0, 0, 0, 0, 32'h0, 0);
    repeat (20) tick();
    check("perf.saturate", 32'(stall_count), 32'hF);
    drive(0, 1, 0, 0, 32'h0, 0);
    tick();
    drive(0, 0, 0, 0, 32'h0, 0);
    tick();
    check("perf.flush_keeps", 32'(stall_count), 32'hF);
    check("perf.flush_valid", 32'(out_valid), 32'h0);
    drive(1, 0, 0, 0, 32'h0, 0);
    tick();
    check("perf.reset_clears", 32'(stall_count), 32'h0);
`endif

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
